vector_packetizer: RTL



---
 rtl/vector_packetizer_pkg.sv | 25 ++
 rtl/vector_packetizer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/vector_packetizer_pkg.sv
// Shared flit-type codes, packetizer FSM states and flit-geometry helpers
// for the vector packetizer.
package vector_packetizer_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } pkt_state_t;

  // Elements carried by one payload flit.
  function automatic int calc_epf(input int pkt_len, input int dw);
    return (pkt_len - 2) / dw;
  endfunction

  // Payload flits needed for one vector.
  function automatic int calc_nbody(input int features, input int epf);
    return (features + epf - 1) / epf;
  endfunction

endpackage

// File: rtl/vector_packetizer.sv
// Serializes one feature vector into a NoC packet (head + payload flits).
// VPKT_BACK2BACK_EN: accept the next vector on the tail-consume edge (zero bubble).
module vector_packetizer
  import vector_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FEATURES      = 16,
  parameter int PACKET_LENGTH = 34,
  parameter int COORD_LENGTH  = 3,
  parameter int ADDR_LENGTH   = 8,
  parameter int X_COORD       = 1,
  parameter int Y_COORD       = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FEATURES*DATA_WIDTH-1:0] vec_in,
  input  logic                           vec_vld,
  output logic                           vec_rdy,
  input  logic [COORD_LENGTH-1:0]        dst_x,
  input  logic [COORD_LENGTH-1:0]        dst_y,
  input  logic [ADDR_LENGTH-1:0]         dst_addr,
  output logic [PACKET_LENGTH-1:0]       dout,
  output logic                           vld_out,
  input  logic                           read,
  output logic                           busy
);

  localparam int PAY_W   = PACKET_LENGTH - 2;
  localparam int EPF     = calc_epf(PACKET_LENGTH, DATA_WIDTH);
  localparam int NBODY   = calc_nbody(FEATURES, EPF);
  localparam int FLIT_DW = EPF * DATA_WIDTH;
  localparam int PAD_W   = NBODY * FLIT_DW;
  localparam int HDR_W   = 4 * COORD_LENGTH + ADDR_LENGTH;
  localparam int CNT_W   = (NBODY > 1) ? $clog2(NBODY) : 1;
  localparam logic [CNT_W-1:0]        LAST  = CNT_W'(NBODY - 1);
  localparam logic [COORD_LENGTH-1:0] SRC_X = COORD_LENGTH'(X_COORD);
  localparam logic [COORD_LENGTH-1:0] SRC_Y = COORD_LENGTH'(Y_COORD);

  generate
    if (HDR_W > PAY_W) begin : g_hdr_chk
      $error("vector_packetizer: head fields do not fit in flit payload");
    end
    if (EPF < 1) begin : g_epf_chk
      $error("vector_packetizer: flit payload narrower than one element");
    end
  endgenerate

  pkt_state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt, w_sel;
  logic [PAD_W-1:0]         r_vec;
  logic [PACKET_LENGTH-1:0] r_dout, w_dout_nxt, w_head, w_body;
  logic                     r_vld;
  logic                     w_last_rd, w_accept, w_vec_rdy;

  assign w_head = {FLIT_HEAD, PAY_W'({dst_x, dst_y, SRC_X, SRC_Y, dst_addr})};

  // Flit that becomes visible after the current consume: 0 leaving HEAD, cnt+1 in BODY.
  assign w_sel  = (r_state == HEAD) ? '0 : r_cnt + 1'b1;
  assign w_body = {(w_sel == LAST) ? FLIT_TAIL : FLIT_BODY,
                   PAY_W'(r_vec[w_sel*FLIT_DW +: FLIT_DW])};

  assign w_last_rd = (r_state == BODY) && read && (r_cnt == LAST);
`ifdef VPKT_BACK2BACK_EN
  assign w_vec_rdy = !rst && ((r_state == IDLE) || w_last_rd);
`else
  assign w_vec_rdy = !rst && (r_state == IDLE);
`endif
  assign w_accept  = vec_vld && w_vec_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt = HEAD;
        w_cnt_nxt   = '0;
        w_dout_nxt  = w_head;
      end
      HEAD: if (read) begin
        w_state_nxt = BODY;
        w_cnt_nxt   = '0;
        w_dout_nxt  = w_body;
      end
      BODY: if (w_last_rd) begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt = HEAD;
          w_dout_nxt  = w_head;
        end else begin
          w_state_nxt = IDLE;
          w_dout_nxt  = '0;
        end
      end else if (read) begin
        w_cnt_nxt  = r_cnt + 1'b1;
        w_dout_nxt = w_body;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_dout_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_vld   <= (w_state_nxt != IDLE);
    end
  end

  // Slots past FEATURES-1 come from the zero-extension here.
  always_ff @(posedge clk) begin
    if (w_accept) r_vec <= PAD_W'(vec_in);
  end

  assign vec_rdy = w_vec_rdy;
  assign dout    = r_dout;
  assign vld_out = r_vld;
  assign busy    = (r_state != IDLE);

endmodule
